// File: rtl/seq_div_pkg.sv
// Shared types for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Trial subtraction at WIDTH+1 bits; a clear sign bit means the divisor fits.
    always_comb begin
        w_shifted = {rem, dividend_msb};
        w_trial   = w_shifted - {1'b0, divisor};
        q_bit     = ~w_trial[WIDTH];
        if (q_bit) begin
            next_rem = w_trial[WIDTH-1:0];
        end else begin
            next_rem = w_shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_dbz;

    logic             w_idle;
    logic             w_right_zero;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_msb;
    logic [WIDTH-1:0] w_step_div;
    logic [WIDTH-1:0] w_next_rem;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_next_quot;

    assign w_idle       = (r_state == IDLE);
    assign w_right_zero = (right == {WIDTH{1'b0}});
    assign in_ready     = w_idle;
    assign out_valid    = (r_state == DONE);
    assign quotient     = r_q_out;
    assign remainder    = r_r_out;
    assign div_by_zero  = r_dbz;

    // The accepting edge already performs the first step from a cleared partial
    // remainder, so the result is visible on the WIDTH-th edge after accept.
    assign w_step_rem  = w_idle ? {WIDTH{1'b0}} : r_rem;
    assign w_step_msb  = w_idle ? left[WIDTH-1] : r_dividend[WIDTH-1];
    assign w_step_div  = w_idle ? right : r_divisor;
    assign w_next_quot = (r_quot << 1) | {{(WIDTH-1){1'b0}}, w_q_bit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (w_step_rem),
        .dividend_msb (w_step_msb),
        .divisor      (w_step_div),
        .next_rem     (w_next_rem),
        .q_bit        (w_q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_right_zero) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = BUSY;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, restoring iteration and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= {CW{1'b0}};
            r_dividend <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
            r_quot     <= {WIDTH{1'b0}};
            r_q_out    <= {WIDTH{1'b0}};
            r_r_out    <= {WIDTH{1'b0}};
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && w_right_zero) begin
                        r_q_out <= {WIDTH{1'b1}};
                        r_r_out <= left;
                        r_dbz   <= 1'b1;
                    end else if (in_valid) begin
                        r_dividend <= {left[WIDTH-2:0], 1'b0};
                        r_divisor  <= right;
                        r_rem      <= w_next_rem;
                        r_quot     <= {{(WIDTH-1){1'b0}}, w_q_bit};
                        r_cnt      <= CNT_LAST;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                BUSY: begin
                    r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                    r_rem      <= w_next_rem;
                    r_quot     <= w_next_quot;
                    r_cnt      <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_q_out <= w_next_quot;
                        r_r_out <= w_next_rem;
                        r_dbz   <= 1'b0;
                    end else begin
                        r_dbz <= r_dbz;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: 32-bit directed scenarios plus an 8-bit random scoreboard run.
module tb_seq_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dbz;
    logic [31:0] a_left, a_right, a_q, a_r;
    logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dbz;
    logic [7:0]  b_left, b_right, b_q, b_r;

    typedef struct packed { logic [31:0] q; logic [31:0] r; logic dbz; } res32_t;
    typedef struct packed { logic [7:0]  q; logic [7:0]  r; logic dbz; } res8_t;
    res32_t exp32[$];
    res8_t  exp8[$];

    seq_div #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .left(a_left), .right(a_right), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .quotient(a_q), .remainder(a_r), .div_by_zero(a_dbz)
    );

    seq_div #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .left(b_left), .right(b_right), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .quotient(b_q), .remainder(b_r), .div_by_zero(b_dbz)
    );

    function automatic res32_t model32(input logic [31:0] l, input logic [31:0] r);
        res32_t m;
        if (r == 32'd0) begin
            m.q = 32'hFFFF_FFFF; m.r = l; m.dbz = 1'b1;
        end else begin
            m.q = l / r; m.r = l % r; m.dbz = 1'b0;
        end
        return m;
    endfunction

    function automatic res8_t model8(input logic [7:0] l, input logic [7:0] r);
        res8_t m;
        if (r == 8'd0) begin
            m.q = 8'hFF; m.r = l; m.dbz = 1'b1;
        end else begin
            m.q = l / r; m.r = l % r; m.dbz = 1'b0;
        end
        return m;
    endfunction

    // Offer one operation, wait (bounded) for acceptance, push its expected result.
    task automatic send32(input logic [31:0] l, input logic [31:0] r, output int acc_cyc);
        int n;
        @(negedge clk);
        a_left = l; a_right = r; a_in_valid = 1'b1;
        n = 0;
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", a_in_ready);
        end
        exp32.push_back(model32(l, r));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        a_in_valid = 1'b0;
        a_left = $urandom();
        a_right = $urandom();
    endtask

    // Count edges after accept until out_valid is observed (bounded).
    task automatic wait_out32(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_out_valid && lat < 200);
    endtask

    task automatic consume32();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_left = 32'd0; a_right = 32'd0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_left = 8'd0; b_right = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_in_ready, a_out_valid, a_q, a_r, a_dbz} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b q=%h r=%h dbz=%b required rdy=1 vld=0 q=0 r=0 dbz=0",
                     a_in_ready, a_out_valid, a_q, a_r, a_dbz);
        end
        checks++;
        if ({b_in_ready, b_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_state8 rdy=%b vld=%b required rdy=1 vld=0", b_in_ready, b_out_valid);
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int t, lat;
        res32_t e;
        send32(32'd100, 32'd7, t);
        wait_out32(lat);
        e = exp32.pop_front();
        checks++;
        if (lat != 32) begin
            errors++;
            $display("FAIL basic_latency got=%0d required=32", lat);
        end
        checks++;
        if ({a_q, a_r, a_dbz} !== {e.q, e.r, e.dbz} || e.q !== 32'd14 || e.r !== 32'd2) begin
            errors++;
            $display("FAIL basic_result q=%0d r=%0d dbz=%b required q=14 r=2 dbz=0", a_q, a_r, a_dbz);
        end
        consume32();
    endtask

    task automatic test_div_zero();
        int t, lat;
        res32_t e;
        send32(32'd5, 32'd0, t);
        wait_out32(lat);
        e = exp32.pop_front();
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL dbz_latency got=%0d required=1", lat);
        end
        checks++;
        if ({a_q, a_r, a_dbz} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            errors++;
            $display("FAIL dbz_result q=%h r=%0d dbz=%b required q=ffffffff r=5 dbz=1", a_q, a_r, a_dbz);
        end
        consume32();
    endtask

    task automatic test_boundary();
        logic [31:0] ls [5] = '{32'hFFFF_FFFF, 32'd3, 32'd77, 32'd0, 32'd1};
        logic [31:0] rs [5] = '{32'd1, 32'd10, 32'd77, 32'd9, 32'hFFFF_FFFF};
        int t, lat;
        res32_t e;
        for (int i = 0; i < 5; i++) begin
            send32(ls[i], rs[i], t);
            wait_out32(lat);
            e = exp32.pop_front();
            checks++;
            if (lat != 32 || {a_q, a_r, a_dbz} !== {e.q, e.r, e.dbz}) begin
                errors++;
                $display("FAIL boundary_%0d lat=%0d q=%h r=%h dbz=%b required lat=32 q=%h r=%h dbz=%b",
                         i, lat, a_q, a_r, a_dbz, e.q, e.r, e.dbz);
            end
            consume32();
        end
    endtask

    task automatic test_backpressure();
        int t, lat;
        res32_t e;
        send32(32'd123456789, 32'd1000, t);
        wait_out32(lat);
        e = exp32.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({a_out_valid, a_in_ready, a_q, a_r, a_dbz} !== {1'b1, 1'b0, e.q, e.r, e.dbz}) begin
                errors++;
                $display("FAIL hold_%0d vld=%b rdy=%b q=%0d r=%0d required vld=1 rdy=0 q=%0d r=%0d",
                         i, a_out_valid, a_in_ready, a_q, a_r, e.q, e.r);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        checks++;
        if ({a_out_valid, a_in_ready, a_q, a_r} !== {1'b0, 1'b1, e.q, e.r}) begin
            errors++;
            $display("FAIL release vld=%b rdy=%b q=%0d r=%0d required vld=0 rdy=1 q=%0d r=%0d",
                     a_out_valid, a_in_ready, a_q, a_r, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, lat;
        a_out_ready = 1'b1;
        send32(32'd50, 32'd3, t1);
        send32(32'd60, 32'd4, t2);
        checks++;
        if (t2 - t1 != 33) begin
            errors++;
            $display("FAIL ii_normal got=%0d required=33", t2 - t1);
        end
        send32(32'd9, 32'd0, t1);
        send32(32'd8, 32'd0, t2);
        checks++;
        if (t2 - t1 != 2) begin
            errors++;
            $display("FAIL ii_dbz got=%0d required=2", t2 - t1);
        end
        wait_out32(lat);
        @(negedge clk);
        a_out_ready = 1'b0;
        exp32.delete();
    endtask

    task automatic test_reset_mid_op();
        int t, lat;
        res32_t e;
        send32(32'hDEAD_BEEF, 32'd3, t);
        repeat (9) @(posedge clk);
        #2;
        a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_q, a_r, a_dbz} !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid vld=%b rdy=%b q=%h r=%h dbz=%b required vld=0 rdy=1 q=0 r=0 dbz=0",
                     a_out_valid, a_in_ready, a_q, a_r, a_dbz);
        end
        exp32.delete();
        @(negedge clk);
        a_rst_n = 1'b1;
        send32(32'd1000, 32'd33, t);
        wait_out32(lat);
        e = exp32.pop_front();
        checks++;
        if ({a_q, a_r, a_dbz} !== {32'd30, 32'd10, 1'b0} || lat != 32) begin
            errors++;
            $display("FAIL after_reset q=%0d r=%0d lat=%0d required q=30 r=10 lat=32 (model q=%0d)",
                     a_q, a_r, lat, e.q);
        end
        consume32();
    endtask

    task automatic test_random8();
        int   sent = 0, got = 0, budget = 0;
        logic pend = 1'b0;
        res8_t e;
        while ((sent < 2000 || exp8.size() != 0) && budget < 60000) begin
            @(negedge clk);
            budget++;
            if (pend) begin
                sent++;
                b_in_valid = 1'b0;
                pend = 1'b0;
            end
            b_out_ready = ($urandom_range(1) == 1);
            if (b_out_valid && b_out_ready) begin
                got++;
                checks++;
                if (exp8.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra q=%h r=%h dbz=%b required no result", b_q, b_r, b_dbz);
                end else begin
                    e = exp8.pop_front();
                    if ({b_q, b_r, b_dbz} !== {e.q, e.r, e.dbz}) begin
                        errors++;
                        $display("FAIL rand_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                                 b_q, b_r, b_dbz, e.q, e.r, e.dbz);
                    end
                end
            end
            if (sent < 2000 && !b_in_valid && $urandom_range(1) == 1) begin
                b_left  = 8'($urandom());
                b_right = ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
                b_in_valid = 1'b1;
            end else if (b_in_valid && !b_in_ready && $urandom_range(3) == 0) begin
                b_in_valid = 1'b0;
            end
            if (b_in_valid && b_in_ready) begin
                exp8.push_back(model8(b_left, b_right));
                pend = 1'b1;
            end
        end
        checks++;
        if (got != 2000 || sent != 2000 || exp8.size() != 0) begin
            errors++;
            $display("FAIL rand_count got=%0d sent=%0d pending=%0d required got=2000 sent=2000 pending=0",
                     got, sent, exp8.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
